// File: rtl/float32_pkg.sv
// Shared field widths, constants and FSM state type for the float32 multiplier.
package float32_pkg;

    localparam int EXP_W  = 8;
    localparam int MAN_W  = 23;
    localparam int SIG_W  = 24;
    localparam int PROD_W = 48;
    localparam int EXP_IW = 10;

    localparam logic [EXP_IW-1:0] BIAS = 10'd127;

    localparam logic [31:0] QNAN     = 32'h7FC0_0000;
    localparam logic [31:0] POS_INF  = 32'h7F80_0000;
    localparam logic [31:0] NEG_INF  = 32'hFF80_0000;
    localparam logic [31:0] POS_ZERO = 32'h0000_0000;
    localparam logic [31:0] NEG_ZERO = 32'h8000_0000;

    typedef enum logic [2:0] {
        S_IDLE,
        S_UNPACK,
        S_MUL,
        S_NORM,
        S_ROUND
    } state_e;

    function automatic logic [31:0] signed_inf(input logic s);
        return s ? NEG_INF : POS_INF;
    endfunction

    function automatic logic [31:0] signed_zero(input logic s);
        return s ? NEG_ZERO : POS_ZERO;
    endfunction

endpackage

// File: rtl/mant_mul_seq.sv
// Iterative 24x24 unsigned shift-add multiplier, one multiplier bit per cycle.
module mant_mul_seq
    import float32_pkg::*;
(
    input  logic              clk,
    input  logic              nRST,
    input  logic              start_i,
    input  logic [SIG_W-1:0]  a_i,
    input  logic [SIG_W-1:0]  b_i,
    output logic              done_o,
    output logic [PROD_W-1:0] prod_o
);

    logic              run_q;
    logic [4:0]        cnt_q;
    logic [PROD_W-1:0] mcand_q;
    logic [SIG_W-1:0]  mplier_q;
    logic [PROD_W-1:0] acc_q;

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            run_q    <= 1'b0;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
        end else if (start_i) begin
            run_q    <= 1'b1;
            cnt_q    <= '0;
            mcand_q  <= {{(PROD_W-SIG_W){1'b0}}, a_i};
            mplier_q <= b_i;
            acc_q    <= '0;
        end else if (run_q) begin
            if (mplier_q[0])
                acc_q <= acc_q + mcand_q;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + 5'd1;
            if (cnt_q == 5'd23)
                run_q <= 1'b0;
        end
    end

    // High in the cycle whose closing edge retires the last partial product.
    assign done_o = run_q && (cnt_q == 5'd23);
    assign prod_o = acc_q;

endmodule

// File: rtl/float32_mul.sv
// Multi-cycle IEEE-754 single-precision multiplier (RNE, denormals flushed to zero).
module float32_mul
    import float32_pkg::*;
(
    input  logic        clk,
    input  logic        nRST,
    input  logic [31:0] leftArg,
    input  logic [31:0] rightArg,
    input  logic        loadArgs,
    output logic [2:0]  status,
    output logic        busy,
    output logic [31:0] product
);

    state_e            state_q;
    logic              busy_q;
    logic [31:0]       product_q;
    logic [2:0]        status_q;
    logic [31:0]       a_q, b_q;
    logic              sign_q;
    logic [EXP_IW-1:0] exp_q;
    logic [SIG_W-1:0]  mant_q;
    logic              g_q, r_q, s_q;
    logic              spec_q;
    logic [31:0]       fres_q;
    logic [2:0]        fst_q;

    logic [EXP_W-1:0]  ea, eb;
    logic              sgn, l_nan, r_nan, l_inf, r_inf, l_zero, r_zero, l_den, r_den, special;
    logic [EXP_IW-1:0] exp_sum;
    logic [31:0]       spec_res;
    logic [2:0]        spec_st;

    assign ea      = a_q[30:23];
    assign eb      = b_q[30:23];
    assign sgn     = a_q[31] ^ b_q[31];
    assign l_nan   = (ea == 8'hFF) && (a_q[22:0] != '0);
    assign r_nan   = (eb == 8'hFF) && (b_q[22:0] != '0);
    assign l_inf   = (ea == 8'hFF) && (a_q[22:0] == '0);
    assign r_inf   = (eb == 8'hFF) && (b_q[22:0] == '0);
    assign l_zero  = (ea == 8'h00);
    assign r_zero  = (eb == 8'h00);
    assign l_den   = l_zero && (a_q[22:0] != '0);
    assign r_den   = r_zero && (b_q[22:0] != '0);
    assign special = l_nan | r_nan | l_inf | r_inf | l_zero | r_zero;
    assign exp_sum = {2'b00, ea} + {2'b00, eb} - BIAS;

    // A denormal partner of Inf counts as zero, so Inf*denormal is NaN.
    always_comb begin
        spec_res = signed_zero(sgn);
        spec_st  = {2'b00, l_den | r_den};
        if (l_nan || r_nan || (l_inf && r_zero) || (r_inf && l_zero)) begin
            spec_res = QNAN;
            spec_st  = 3'b100;
        end else if (l_inf || r_inf) begin
            spec_res = signed_inf(sgn);
            spec_st  = 3'b010;
        end
    end

    logic              mul_start, mul_done;
    logic [PROD_W-1:0] mul_prod;

    assign mul_start = (state_q == S_UNPACK) && !special;

    mant_mul_seq u_mul (
        .clk    (clk),
        .nRST   (nRST),
        .start_i(mul_start),
        .a_i    ({1'b1, a_q[22:0]}),
        .b_i    ({1'b1, b_q[22:0]}),
        .done_o (mul_done),
        .prod_o (mul_prod)
    );

    logic [SIG_W-1:0] n_mant;
    logic             n_g, n_r, n_s;

    always_comb begin
        if (mul_prod[47]) begin
            n_mant = mul_prod[47:24];
            n_g    = mul_prod[23];
            n_r    = mul_prod[22];
            n_s    = |mul_prod[21:0];
        end else begin
            n_mant = mul_prod[46:23];
            n_g    = mul_prod[22];
            n_r    = mul_prod[21];
            n_s    = |mul_prod[20:0];
        end
    end

    logic              rnd_up;
    logic [SIG_W:0]    rnd_sum;
    logic [EXP_IW-1:0] rnd_exp;
    logic [MAN_W-1:0]  rnd_frac;
    logic [31:0]       rnd_res;
    logic [2:0]        rnd_st;

    assign rnd_up   = g_q & (r_q | s_q | mant_q[0]);
    assign rnd_sum  = {1'b0, mant_q} + {{SIG_W{1'b0}}, rnd_up};
    assign rnd_exp  = exp_q + {{(EXP_IW-1){1'b0}}, rnd_sum[SIG_W]};
    assign rnd_frac = rnd_sum[SIG_W] ? rnd_sum[SIG_W-1:1] : rnd_sum[MAN_W-1:0];

    always_comb begin
        rnd_res = {sign_q, rnd_exp[7:0], rnd_frac};
        rnd_st  = 3'b000;
        if ($signed(rnd_exp) >= 10'sd255) begin
            rnd_res = signed_inf(sign_q);
            rnd_st  = 3'b010;
        end else if ($signed(rnd_exp) <= 10'sd0) begin
            rnd_res = signed_zero(sign_q);
            rnd_st  = 3'b001;
        end
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state_q   <= S_IDLE;
            busy_q    <= 1'b0;
            product_q <= '0;
            status_q  <= '0;
            a_q       <= '0;
            b_q       <= '0;
            sign_q    <= 1'b0;
            exp_q     <= '0;
            mant_q    <= '0;
            g_q       <= 1'b0;
            r_q       <= 1'b0;
            s_q       <= 1'b0;
            spec_q    <= 1'b0;
            fres_q    <= '0;
            fst_q     <= '0;
        end else begin
            case (state_q)
                S_IDLE: if (loadArgs) begin
                    a_q     <= leftArg;
                    b_q     <= rightArg;
                    busy_q  <= 1'b1;
                    state_q <= S_UNPACK;
                end
                S_UNPACK: begin
                    sign_q  <= sgn;
                    exp_q   <= exp_sum;
                    spec_q  <= special;
                    fres_q  <= spec_res;
                    fst_q   <= spec_st;
                    state_q <= special ? S_ROUND : S_MUL;
                end
                S_MUL: if (mul_done) state_q <= S_NORM;
                S_NORM: begin
                    mant_q  <= n_mant;
                    g_q     <= n_g;
                    r_q     <= n_r;
                    s_q     <= n_s;
                    exp_q   <= exp_q + {{(EXP_IW-1){1'b0}}, mul_prod[47]};
                    state_q <= S_ROUND;
                end
                S_ROUND: begin
                    product_q <= spec_q ? fres_q : rnd_res;
                    status_q  <= spec_q ? fst_q : rnd_st;
                    busy_q    <= 1'b0;
                    state_q   <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign product = product_q;
    assign status  = status_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_float32_mul.sv
// Randomised and directed check of float32_mul against an integer-arithmetic reference.
module tb_float32_mul;

    logic        clk = 1'b0;
    logic        nRST;
    logic [31:0] leftArg, rightArg;
    logic        loadArgs;
    logic [2:0]  status;
    logic        busy;
    logic [31:0] product;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    float32_mul dut (
        .clk     (clk),
        .nRST    (nRST),
        .leftArg (leftArg),
        .rightArg(rightArg),
        .loadArgs(loadArgs),
        .status  (status),
        .busy    (busy),
        .product (product)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Reference: exact integer product, remainder-vs-half rounding, then range checks.
    function automatic void ref_mul(input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] p, output logic [2:0] st,
                                    output int lat);
        int ea, eb, e, drop;
        logic s, an, bn, ai, bi, az, bz;
        longint unsigned m, kept, rem, half;
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        s  = a[31] ^ b[31];
        an = (ea == 255) && (a[22:0] != 0);
        bn = (eb == 255) && (b[22:0] != 0);
        ai = (ea == 255) && (a[22:0] == 0);
        bi = (eb == 255) && (b[22:0] == 0);
        az = (ea == 0);
        bz = (eb == 0);
        lat = 2;
        if (an || bn || (ai && bz) || (bi && az)) begin
            p = 32'h7FC00000; st = 3'b100;
        end else if (ai || bi) begin
            p = {s, 8'hFF, 23'd0}; st = 3'b010;
        end else if (az || bz) begin
            p = {s, 31'd0};
            st = {2'b00, (az && a[22:0] != 0) || (bz && b[22:0] != 0)};
        end else begin
            lat  = 27;
            m    = {40'd0, 1'b1, a[22:0]};
            m    = m * {40'd0, 1'b1, b[22:0]};
            drop = m[47] ? 24 : 23;
            kept = m >> drop;
            rem  = m - (kept << drop);
            half = 64'd1 << (drop - 1);
            if (rem > half || (rem == half && kept[0])) kept++;
            e = ea + eb - 127 + (drop - 23);
            if (kept == (64'd1 << 24)) begin
                kept = kept >> 1;
                e++;
            end
            if (e >= 255) begin
                p = {s, 8'hFF, 23'd0}; st = 3'b010;
            end else if (e <= 0) begin
                p = {s, 31'd0}; st = 3'b001;
            end else begin
                p = {s, e[7:0], kept[22:0]}; st = 3'b000;
            end
        end
    endfunction

    // mode 0: single load pulse; 1: junk loads while busy; 2: load held high.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] ep,
                          input logic [2:0] es, input int elat, input int mode);
        int lat = 0;
        leftArg  = a;
        rightArg = b;
        loadArgs = 1'b1;
        @(negedge clk);
        chk("accept", {31'd0, busy}, 32'd1);
        if (mode == 0) loadArgs = 1'b0;
        else if (mode == 1) begin
            leftArg  = $urandom;
            rightArg = $urandom;
        end
        while (busy && lat < 100) begin
            lat++;
            @(negedge clk);
        end
        chk("latency", lat, elat);
        chk("product", product, ep);
        chk("status", {29'd0, status}, {29'd0, es});
        if (mode == 1) begin
            loadArgs = 1'b0;
            @(negedge clk);
            chk("ignored", {31'd0, busy}, 32'd0);
        end
    endtask

    task automatic model_op(input logic [31:0] a, input logic [31:0] b, input int mode);
        logic [31:0] p;
        logic [2:0]  st;
        int          lat;
        ref_mul(a, b, p, st, lat);
        run_op(a, b, p, st, lat, mode);
    endtask

    function automatic logic [31:0] rnd_f();
        int          k;
        logic [7:0]  e;
        logic [22:0] m;
        k = $urandom_range(0, 15);
        if (k == 0)      e = 8'h00;
        else if (k == 1) e = 8'hFF;
        else if (k < 6)  e = 8'($urandom_range(1, 254));
        else             e = 8'($urandom_range(100, 154));
        m = ($urandom_range(0, 3) == 0) ? 23'd0 : 23'($urandom);
        return {1'($urandom), e, m};
    endfunction

    initial begin
        nRST     = 1'b0;
        loadArgs = 1'b0;
        leftArg  = '0;
        rightArg = '0;
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_prod", product, 32'd0);
        chk("rst_stat", {29'd0, status}, 32'd0);
        repeat (2) @(negedge clk);
        nRST = 1'b1;

        run_op(32'h3FC00000, 32'h3FC00000, 32'h40100000, 3'b000, 27, 0);
        run_op(32'hC0000000, 32'h3F000000, 32'hBF800000, 3'b000, 27, 1);
        run_op(32'h7F800000, 32'h00000000, 32'h7FC00000, 3'b100, 2, 0);
        run_op(32'h00800000, 32'h3F000000, 32'h00000000, 3'b001, 27, 0);
        run_op(32'h00400000, 32'h40000000, 32'h00000000, 3'b001, 2, 0);
        run_op(32'h7F000000, 32'h40000000, 32'h7F800000, 3'b010, 27, 0);

        // Abort a multiply partway through; outputs clear at once and nothing leaks out later.
        leftArg  = 32'h3FC00000;
        rightArg = 32'h3FC00000;
        loadArgs = 1'b1;
        @(negedge clk);
        loadArgs = 1'b0;
        repeat (9) @(negedge clk);
        nRST = 1'b0;
        #1;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_prod", product, 32'd0);
        chk("abort_stat", {29'd0, status}, 32'd0);
        @(negedge clk);
        nRST = 1'b1;
        repeat (30) @(negedge clk);
        chk("post_abort_busy", {31'd0, busy}, 32'd0);
        chk("post_abort_prod", product, 32'd0);
        run_op(32'h40000000, 32'h40400000, 32'h40C00000, 3'b000, 27, 0);

        model_op(32'h3F800001, 32'h3F800001, 0);
        model_op(32'h3FFFFFFF, 32'h3FFFFFFF, 0);
        model_op(32'h3F7FFFFF, 32'h3F800001, 0);
        model_op(32'h7F7FFFFF, 32'h3F800001, 0);
        model_op(32'h00FFFFFF, 32'h3F7FFFFF, 0);
        for (int i = 0; i < 40; i++) model_op(rnd_f(), rnd_f(), 0);

        for (int i = 0; i < 5; i++) model_op(rnd_f(), rnd_f(), 2);
        loadArgs = 1'b0;
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/float32_mul.md
FLOAT32_MUL -- requirements
Module: float32_mul

Interface
REQ-001 clk  input  1  global clock; rising edge active.
REQ-002 nRST  input  1  global reset; asynchronous, active-low.
REQ-003 leftArg  input  32  left operand; bit 31 sign, bits 30:23 exponent, bits 22:0 mantissa.
REQ-004 rightArg  input  32  right operand; same format as leftArg.
REQ-005 loadArgs  input  1  argument load strobe; active high.
REQ-006 status  output  3  bit 2 Not a Number, bit 1 Infinity, bit 0 Denormal.
REQ-007 busy  output  1  high while calculating; low means product/status hold a valid result.
REQ-008 product  output  32  IEEE-754 single-precision product leftArg*rightArg.

Function
REQ-009 Handshake: loadArgs sampled high on a rising edge with busy=0 SHALL capture both operands; busy SHALL be high from the next cycle.
REQ-010 loadArgs while busy=1 SHALL be ignored, including the edge on which busy falls; a new load is accepted one cycle later at the earliest.
REQ-011 States: IDLE, UNPACK, MUL, NORM, ROUND; all outputs registered.
REQ-012 IDLE->UNPACK on accepted load; UNPACK->MUL for normal operands; UNPACK->ROUND with forced result for special operands.
REQ-013 MUL: 24x24 unsigned shift-add, one multiplier bit per cycle, exactly 24 cycles; sign = XOR of operand signs; exponent = eL + eR - 127, computed 10 bits signed.
REQ-014 NORM: normalise the 48-bit product by at most one right shift, adjusting the exponent; ROUND: round-to-nearest-even on guard/round/sticky, renormalise on mantissa carry-out.
REQ-015 Latency: normal operands keep busy high exactly 27 cycles; special operands keep busy high exactly 2 cycles.
REQ-016 product and status SHALL update on the same edge busy falls and hold until the next result completes.
REQ-017 Special cases: any NaN operand, or Inf*0, -> 0x7FC00000, status=100.
REQ-018 Inf times a nonzero non-NaN operand -> signed Inf, status=010.
REQ-019 Zero or denormal operand (exponent 0) -> treated as signed zero; denormal input sets status[0]; result is signed zero.
REQ-020 Rounded exponent >= 255 -> signed Inf, status=010; rounded exponent <= 0 -> flushed to signed zero, status=001.
REQ-021 Otherwise status=000.

Reset
REQ-022 nRST low SHALL asynchronously force state IDLE, busy=0, product=0x00000000, status=000, and clear all datapath registers.
REQ-023 Reset asserted mid-operation SHALL abandon the calculation; no partial result appears after release.
REQ-024 The first load is accepted on the first rising edge after nRST deasserts.

Structure
REQ-025 Shared package float32_pkg: field widths, bias 127, canonical NaN 0x7FC00000, signed Inf/zero constants, state enum type.
REQ-026 One sub-module, mant_mul_seq: iterative 24x24 shift-add multiplier with start/done, instantiated once; all other logic in float32_mul.

Verification
REQ-027 0x3FC00000 * 0x3FC00000 (1.5*1.5) -> product 0x40100000, status 000, busy high exactly 27 cycles.
REQ-028 0xC0000000 * 0x3F000000 (-2.0*0.5) -> 0xBF800000, status 000; loadArgs pulsed during busy has no effect.
REQ-029 0x7F000000 * 0x40000000 -> 0x7F800000, status 010; 0x7F800000 * 0x00000000 -> 0x7FC00000, status 100, busy high 2 cycles.
REQ-030 0x00800000 * 0x3F000000 -> 0x00000000, status 001; 0x00400000 * 0x40000000 -> 0x00000000, status 001.
REQ-031 nRST pulsed low 10 cycles into a multiply -> busy=0, product=0, status=000 immediately; the next load 0x40000000 * 0x40400000 -> 0x40C00000.
REQ-032 Back-to-back: loadArgs held high continuously -> a new operation is accepted exactly one cycle after each busy fall, and each result matches its operands.
